pixel_reader: RTL and testbench

PIXEL_READER -- requirements
Module: pixel_reader

---
 rtl/pixel_reader_pkg.sv | 20 ++
 rtl/pixel_reader_fifo2.sv | 61 ++++++
 rtl/pixel_reader.sv | 156 +++++++++++++++
 tb/tb_pixel_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_reader_pkg.sv
// pixel_reader_pkg
// Shared definitions for the quadrant pixel reader: the address and pixel
// widths, and the controller state enum used by pixel_reader.
// No ports; imported by pixel_reader and pix_fifo2.

package pixel_reader_pkg;

    localparam int ADDR_W = 19;
    localparam int PIX_W  = 8;

    // Controller phases: IDLE waits for a request, RUN issues reads, DRAIN
    // waits for the last returned pixel to leave, DONE pulses completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } readerStateT;

endpackage

// File: rtl/pixel_reader_fifo2.sv
// pix_fifo2
// Two-entry skid buffer between the memory return path and the pixel
// consumer. It holds the byte plus its "last pixel" marker.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   push, din     - write one entry (ignored when full)
//   pop           - remove the head entry (ignored when empty)
//   dout          - head entry
//   count         - number of stored entries (0..2)
//   full, empty   - occupancy flags

module pix_fifo2
    import pixel_reader_pkg::*;
#(
    parameter int W = PIX_W + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] slots [2];
    logic         wrPtr;
    logic         rdPtr;
    logic         doPush;
    logic         doPop;

    assign full   = (count == 2'd2);
    assign empty  = (count == 2'd0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = slots[rdPtr];

    // Storage and pointers. A push and a pop in the same cycle move both
    // pointers and leave count where it was.
    always_ff @(posedge clk) begin
        if (reset) begin
            slots[0] <= '0;
            slots[1] <= '0;
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (doPush) begin
                slots[wrPtr] <= din;
                wrPtr        <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            count <= count + 2'(doPush) - 2'(doPop);
        end
    end

endmodule

// File: rtl/pixel_reader.sv
// pixel_reader
// Scans one quadrant of a byte-per-pixel image in row-major order, issuing
// one byte read per pixel to a 1-cycle-latency memory and streaming the
// returned bytes out on a valid/ready interface.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, cuadrante      - scan request and quadrant index {row, col}
//   mem_rd_en, mem_addr   - byte read request to data memory
//   mem_rdata             - read data, valid one cycle after mem_rd_en
//   pixel, pix_valid,
//   pix_ready, pix_last   - output pixel stream, pix_last on final pixel
//   busy, done            - scan in progress / one-cycle completion pulse

module pixel_reader
    import pixel_reader_pkg::*;
#(
    parameter int                IMG_W     = 400,
    parameter int                QUAD_W    = 100,
    parameter int                QUAD_H    = 100,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 19'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        cuadrante,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pixel,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);

    readerStateT       stateQ;
    readerStateT       stateD;
    logic [3:0]        quadQ;
    logic [15:0]       xQ;
    logic [15:0]       yQ;
    logic              inFlightQ;
    logic              inFlightLastQ;
    logic              isLastRead;
    logic              pop;
    logic [2:0]        occupancy;
    logic [ADDR_W-1:0] addrCalc;
    logic [PIX_W:0]    fifoDout;
    logic [1:0]        fifoCount;
    logic              fifoFull;
    logic              fifoEmpty;

    assign pop        = pix_valid && pix_ready;
    assign isLastRead = (xQ == 16'(QUAD_W - 1)) && (yQ == 16'(QUAD_H - 1));

    // A read may only go out if its byte is guaranteed a slot when it comes
    // back: stored entries plus the outstanding read, minus what leaves now.
    assign occupancy = {1'b0, fifoCount} + {2'b0, inFlightQ} - {2'b0, pop};
    assign mem_rd_en = (stateQ == RUN) && (occupancy < 3'd2) && !fifoFull;

    // Modulo-2^19 arithmetic throughout, so the address wraps exactly as a
    // 19-bit truncation of the full sum.
    assign addrCalc = BASE_ADDR
                    + (ADDR_W'(quadQ[3:2]) * ADDR_W'(QUAD_H) + ADDR_W'(yQ)) * ADDR_W'(IMG_W)
                    + ADDR_W'(quadQ[1:0]) * ADDR_W'(QUAD_W)
                    + ADDR_W'(xQ);
    assign mem_addr = mem_rd_en ? addrCalc : '0;

    // Output side. Gating with empty keeps pixel/pix_last at zero whenever
    // nothing is being presented, including right after reset.
    assign pix_valid = !fifoEmpty;
    assign pixel     = fifoEmpty ? '0 : fifoDout[PIX_W-1:0];
    assign pix_last  = !fifoEmpty && fifoDout[PIX_W];

    pix_fifo2 #(.W(PIX_W + 1)) fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inFlightQ),
        .din   ({inFlightLastQ, mem_rdata}),
        .pop   (pop),
        .dout  (fifoDout),
        .count (fifoCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // State register for the scan controller.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state and status outputs. busy covers RUN and DRAIN only, so it
    // is already low in the cycle that done pulses.
    always_comb begin
        stateD = stateQ;
        busy   = 1'b0;
        done   = 1'b0;
        case (stateQ)
            IDLE: begin
                if (start) begin
                    stateD = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (mem_rd_en && isLastRead) begin
                    stateD = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && pix_last) begin
                    stateD = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    // Scan position, latched quadrant and the in-flight tracking. Clearing
    // inFlightQ on reset is what throws away a byte that returns right after
    // an aborted scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            quadQ         <= 4'd0;
            xQ            <= 16'd0;
            yQ            <= 16'd0;
            inFlightQ     <= 1'b0;
            inFlightLastQ <= 1'b0;
        end else begin
            inFlightQ     <= mem_rd_en;
            inFlightLastQ <= mem_rd_en && isLastRead;
            if (stateQ == IDLE && start) begin
                quadQ <= cuadrante;
                xQ    <= 16'd0;
                yQ    <= 16'd0;
            end else if (mem_rd_en) begin
                if (xQ == 16'(QUAD_W - 1)) begin
                    xQ <= 16'd0;
                    yQ <= isLastRead ? 16'd0 : yQ + 16'd1;
                end else begin
                    xQ <= xQ + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_reader.sv
// tb_pixel_reader
// Self-checking bench for pixel_reader on an 8-pixel-wide image with 2x2
// quadrants. The memory returns the low address byte one cycle after a read.
// Expected addresses and pixels are queued when a scan is started and
// popped as the DUT issues reads and hands over pixels.

module tb_pixel_reader;

    localparam int IW = 8;
    localparam int QW = 2;
    localparam int QH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  cuadrante;
    logic        mem_rd_en;
    logic [18:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  pixel;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        busy;
    logic        done;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [8:0]  expPix[$];
    logic [18:0] expAddr[$];

    always #5 clk = ~clk;

    pixel_reader #(
        .IMG_W     (IW),
        .QUAD_W    (QW),
        .QUAD_H    (QH),
        .BASE_ADDR (19'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cuadrante (cuadrante),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .pixel     (pixel),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    // Memory model: mem[a] = a[7:0], one cycle of read latency, unaffected
    // by the DUT reset.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_addr[7:0];
    end

    // Queue the expected reads/pixels of quadrant q and pulse start.
    task automatic applyStimulus(input logic [3:0] q);
        int row = int'(q[3:2]);
        int col = int'(q[1:0]);
        int a;
        for (int y = 0; y < QH; y++) begin
            for (int x = 0; x < QW; x++) begin
                a = (row * QH + y) * IW + col * QW + x;
                expAddr.push_back(19'(a));
                expPix.push_back({(x == QW - 1 && y == QH - 1) ? 1'b1 : 1'b0, 8'(a)});
            end
        end
        @(negedge clk);
        start     = 1'b1;
        cuadrante = q;
        @(negedge clk);
        start = 1'b0;
        #1;
        testsRun++;
        if (busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL busy_after_start q=%0d: got %b, expected 1", q, busy);
        end
    endtask

    // Run one scan to its done pulse. mode 0 keeps pix_ready high, mode 1
    // uses the ready pattern 1,0,0,1,0,1. glitchCyc >= 0 pulses start with
    // quadrant 3 at that cycle of the scan.
    task automatic scanAndCheck(input string name, input int mode, input int glitchCyc);
        int          firstValid = -1;
        int          lastCyc    = -1;
        int          issued     = 0;
        int          popped     = 0;
        bit          finished   = 0;
        bit          prevValid  = 0;
        bit          prevReady  = 0;
        logic [7:0]  prevPix    = '0;
        logic        prevLast   = 1'b0;
        logic [8:0]  e;
        logic [18:0] ea;
        bit          pattern[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            pix_ready = (mode == 0) ? 1'b1 : pattern[cyc % 6];
            if (cyc == glitchCyc) begin
                start     = 1'b1;
                cuadrante = 4'd3;
            end else if (cyc == glitchCyc + 1) begin
                start = 1'b0;
            end
            #1;
            if (lastCyc >= 0 && cyc == lastCyc + 1) begin
                testsRun++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL %s done_pulse: got done=%b busy=%b, expected done=1 busy=0", name, done, busy);
                end
                finished = 1;
            end else begin
                testsRun++;
                if (done !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL %s done_early cyc=%0d: got %b, expected 0", name, cyc, done);
                end
                if (mem_rd_en) begin
                    issued++;
                    testsRun++;
                    if (expAddr.size() == 0) begin
                        testsFailed++;
                        $display("[TB] FAIL %s extra_read: got addr %0d, expected no read", name, mem_addr);
                    end else begin
                        ea = expAddr.pop_front();
                        if (mem_addr !== ea) begin
                            testsFailed++;
                            $display("[TB] FAIL %s read_addr: got %0d, expected %0d", name, mem_addr, ea);
                        end
                    end
                end
                if (pix_valid && firstValid < 0) firstValid = cyc;
                if (prevValid && !prevReady) begin
                    testsRun++;
                    if (pix_valid !== 1'b1 || pixel !== prevPix || pix_last !== prevLast) begin
                        testsFailed++;
                        $display("[TB] FAIL %s stall_stable: got v=%b pix=%0d last=%b, expected v=1 pix=%0d last=%b",
                                 name, pix_valid, pixel, pix_last, prevPix, prevLast);
                    end
                end
                if (pix_valid && pix_ready) begin
                    popped++;
                    testsRun++;
                    if (expPix.size() == 0) begin
                        testsFailed++;
                        $display("[TB] FAIL %s extra_pixel: got %0d, expected none", name, pixel);
                    end else begin
                        e = expPix.pop_front();
                        if ({pix_last, pixel} !== e) begin
                            testsFailed++;
                            $display("[TB] FAIL %s pixel: got %0d last=%b, expected %0d last=%b",
                                     name, pixel, pix_last, e[7:0], e[8]);
                        end
                    end
                    if (pix_last) lastCyc = cyc;
                end
                testsRun++;
                if (issued - popped > 2) begin
                    testsFailed++;
                    $display("[TB] FAIL %s occupancy: got %0d outstanding, expected at most 2", name, issued - popped);
                end
                prevValid = pix_valid;
                prevReady = pix_ready;
                prevPix   = pixel;
                prevLast  = pix_last;
            end
        end
        testsRun++;
        if (!finished) begin
            testsFailed++;
            $display("[TB] FAIL %s timeout: got no done pulse, expected done within 60 cycles", name);
        end
        testsRun++;
        if (firstValid != 2) begin
            testsFailed++;
            $display("[TB] FAIL %s first_valid_latency: got %0d, expected 2", name, firstValid);
        end
        if (mode == 0) begin
            testsRun++;
            if (lastCyc - firstValid != QW * QH - 1) begin
                testsFailed++;
                $display("[TB] FAIL %s throughput: got span %0d, expected %0d", name, lastCyc - firstValid, QW * QH - 1);
            end
        end
        testsRun++;
        if (expPix.size() != 0 || expAddr.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL %s leftover: got %0d pixels %0d reads pending, expected 0",
                     name, expPix.size(), expAddr.size());
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        cuadrante = 4'd0;
        pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        testsRun++;
        if ({mem_rd_en, mem_addr, pixel, pix_valid, pix_last, busy, done} !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {mem_rd_en, mem_addr, pixel, pix_valid, pix_last, busy, done});
        end
        reset = 1'b0;
    endtask

    task automatic test_quadrant5();
        applyStimulus(4'd5);
        scanAndCheck("quad5", 0, -1);
    endtask

    task automatic test_corners();
        applyStimulus(4'd15);
        scanAndCheck("quad15", 0, -1);
        applyStimulus(4'd0);
        scanAndCheck("quad0", 0, -1);
    endtask

    task automatic test_backpressure();
        applyStimulus(4'd5);
        scanAndCheck("quad5_stall", 1, -1);
    endtask

    task automatic test_start_ignored();
        applyStimulus(4'd5);
        scanAndCheck("quad5_restart", 0, 1);
    endtask

    task automatic test_reset_abort();
        applyStimulus(4'd5);
        pix_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        testsRun++;
        if ({mem_rd_en, mem_addr, pixel, pix_valid, pix_last, busy, done} !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL abort_outputs: got %h, expected 0",
                     {mem_rd_en, mem_addr, pixel, pix_valid, pix_last, busy, done});
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (pix_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_discard: got pix_valid=%b, expected 0", pix_valid);
        end
        expPix.delete();
        expAddr.delete();
        applyStimulus(4'd0);
        scanAndCheck("quad0_after_abort", 0, -1);
    endtask

    task automatic test_back_to_back();
        applyStimulus(4'd5);
        scanAndCheck("b2b_first", 0, -1);
        applyStimulus(4'd15);
        scanAndCheck("b2b_second", 0, -1);
    endtask

    initial begin
        test_reset();
        test_quadrant5();
        test_corners();
        test_backpressure();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
